wb_skid_stage: RTL and testbench

WB_SKID_STAGE -- requirements
Module: wb_skid_stage

---
 rtl/wb_skid_stage_pkg.sv | 16 +
 rtl/wb_skid_stage_entry.sv | 63 ++++++
 rtl/wb_skid_stage.sv | 143 ++++++++++++++
 tb/tb_wb_skid_stage.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_skid_stage_pkg.sv
// Shared constants and state encoding for the write-back skid stage.
package wb_skid_stage_pkg;

   localparam logic RST_ENABLE    = 1'b1;
   localparam logic WRITE_DISABLE = 1'b0;
   localparam int   REG_BUS_W     = 32;
   localparam int   REG_ADDR_W    = 5;

   // Encoding doubles as the occupancy count.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } skid_state_e;

endpackage

// File: rtl/wb_skid_stage_entry.sv
// One buffered write-back entry: payload register with load, enable-clear and reset.
module wb_skid_entry
   import wb_skid_stage_pkg::*;
#(
   parameter int DW  = REG_BUS_W,
   parameter int AW  = REG_ADDR_W,
   parameter int NCH = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_i,
   input  logic              clear_i,
   input  logic [NCH-1:0]    we_i,
   input  logic [NCH*AW-1:0] waddr_i,
   input  logic [NCH*DW-1:0] wdata_i,
   input  logic              whilo_i,
   input  logic [DW-1:0]     hi_i,
   input  logic [DW-1:0]     lo_i,
   output logic [NCH-1:0]    we_o,
   output logic [NCH*AW-1:0] waddr_o,
   output logic [NCH*DW-1:0] wdata_o,
   output logic              whilo_o,
   output logic [DW-1:0]     hi_o,
   output logic [DW-1:0]     lo_o
);

   logic [NCH-1:0]    we_q;
   logic [NCH*AW-1:0] waddr_q;
   logic [NCH*DW-1:0] wdata_q;
   logic              whilo_q;
   logic [DW-1:0]     hi_q;
   logic [DW-1:0]     lo_q;

   // Clear drops only the enables so address/data keep their last values.
   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         we_q    <= {NCH{WRITE_DISABLE}};
         waddr_q <= '0;
         wdata_q <= '0;
         whilo_q <= WRITE_DISABLE;
         hi_q    <= '0;
         lo_q    <= '0;
      end else if (clear_i) begin
         we_q    <= {NCH{WRITE_DISABLE}};
         whilo_q <= WRITE_DISABLE;
      end else if (load_i) begin
         we_q    <= we_i;
         waddr_q <= waddr_i;
         wdata_q <= wdata_i;
         whilo_q <= whilo_i;
         hi_q    <= hi_i;
         lo_q    <= lo_i;
      end
   end

   assign we_o    = we_q;
   assign waddr_o = waddr_q;
   assign wdata_o = wdata_q;
   assign whilo_o = whilo_q;
   assign hi_o    = hi_q;
   assign lo_o    = lo_q;

endmodule

// File: rtl/wb_skid_stage.sv
// Two-entry skid buffer for the write-back payload; all outputs come from flops.
module wb_skid_stage
   import wb_skid_stage_pkg::*;
#(
   parameter int DW  = REG_BUS_W,
   parameter int AW  = REG_ADDR_W,
   parameter int NCH = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [NCH-1:0]    in_we,
   input  logic [NCH*AW-1:0] in_waddr,
   input  logic [NCH*DW-1:0] in_wdata,
   input  logic              in_whilo,
   input  logic [DW-1:0]     in_hi,
   input  logic [DW-1:0]     in_lo,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [NCH-1:0]    out_we,
   output logic [NCH*AW-1:0] out_waddr,
   output logic [NCH*DW-1:0] out_wdata,
   output logic              out_whilo,
   output logic [DW-1:0]     out_hi,
   output logic [DW-1:0]     out_lo,
   output logic [1:0]        occupancy
);

   skid_state_e state_q, state_d;

   logic push, pop;
   logic main_load, main_clear, main_from_skid, skid_load, skid_clear;

   logic [NCH-1:0]    skid_we,    main_we_d;
   logic [NCH*AW-1:0] skid_waddr, main_waddr_d;
   logic [NCH*DW-1:0] skid_wdata, main_wdata_d;
   logic              skid_whilo, main_whilo_d;
   logic [DW-1:0]     skid_hi,    main_hi_d;
   logic [DW-1:0]     skid_lo,    main_lo_d;

   assign in_ready  = (state_q != ST_TWO);
   assign out_valid = (state_q != ST_EMPTY);
   assign occupancy = state_q;

   assign push = in_valid & in_ready;
   assign pop  = out_valid & out_ready;

   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) state_q <= ST_EMPTY;
      else                   state_q <= state_d;
   end

   always_comb begin
      state_d        = state_q;
      main_load      = 1'b0;
      main_clear     = 1'b0;
      main_from_skid = 1'b0;
      skid_load      = 1'b0;
      skid_clear     = 1'b0;
      if (flush) begin
         state_d    = ST_EMPTY;
         main_clear = 1'b1;
         skid_clear = 1'b1;
      end else begin
         unique case (state_q)
            ST_EMPTY: begin
               if (push) begin
                  state_d   = ST_ONE;
                  main_load = 1'b1;
               end
            end
            ST_ONE: begin
               if (push && !pop) begin
                  state_d   = ST_TWO;
                  skid_load = 1'b1;
               end else if (pop && !push) begin
                  // Emptying: drop enables so idle outputs never look like writes.
                  state_d    = ST_EMPTY;
                  main_clear = 1'b1;
               end else if (push && pop) begin
                  main_load = 1'b1;
               end
            end
            ST_TWO: begin
               if (pop) begin
                  state_d        = ST_ONE;
                  main_load      = 1'b1;
                  main_from_skid = 1'b1;
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end
   end

   assign main_we_d    = main_from_skid ? skid_we    : in_we;
   assign main_waddr_d = main_from_skid ? skid_waddr : in_waddr;
   assign main_wdata_d = main_from_skid ? skid_wdata : in_wdata;
   assign main_whilo_d = main_from_skid ? skid_whilo : in_whilo;
   assign main_hi_d    = main_from_skid ? skid_hi    : in_hi;
   assign main_lo_d    = main_from_skid ? skid_lo    : in_lo;

   wb_skid_entry #(.DW(DW), .AW(AW), .NCH(NCH)) u_main (
      .clk     (clk),
      .rst     (rst),
      .load_i  (main_load),
      .clear_i (main_clear),
      .we_i    (main_we_d),
      .waddr_i (main_waddr_d),
      .wdata_i (main_wdata_d),
      .whilo_i (main_whilo_d),
      .hi_i    (main_hi_d),
      .lo_i    (main_lo_d),
      .we_o    (out_we),
      .waddr_o (out_waddr),
      .wdata_o (out_wdata),
      .whilo_o (out_whilo),
      .hi_o    (out_hi),
      .lo_o    (out_lo)
   );

   wb_skid_entry #(.DW(DW), .AW(AW), .NCH(NCH)) u_skid (
      .clk     (clk),
      .rst     (rst),
      .load_i  (skid_load),
      .clear_i (skid_clear),
      .we_i    (in_we),
      .waddr_i (in_waddr),
      .wdata_i (in_wdata),
      .whilo_i (in_whilo),
      .hi_i    (in_hi),
      .lo_i    (in_lo),
      .we_o    (skid_we),
      .waddr_o (skid_waddr),
      .wdata_o (skid_wdata),
      .whilo_o (skid_whilo),
      .hi_o    (skid_hi),
      .lo_o    (skid_lo)
   );

endmodule

// File: tb/tb_wb_skid_stage.sv
// Bench for wb_skid_stage: FIFO scoreboard plus per-cycle vector table and corner sequences.
module tb_wb_skid_stage;

   localparam int DW  = 32;
   localparam int AW  = 5;
   localparam int NCH = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst, flush, in_valid, in_ready, out_valid, out_ready;
   logic [NCH-1:0]    in_we, out_we;
   logic [NCH*AW-1:0] in_waddr, out_waddr;
   logic [NCH*DW-1:0] in_wdata, out_wdata;
   logic              in_whilo, out_whilo;
   logic [DW-1:0]     in_hi, in_lo, out_hi, out_lo;
   logic [1:0]        occupancy;

   wb_skid_stage #(.DW(DW), .AW(AW), .NCH(NCH)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_we     (in_we),
      .in_waddr  (in_waddr),
      .in_wdata  (in_wdata),
      .in_whilo  (in_whilo),
      .in_hi     (in_hi),
      .in_lo     (in_lo),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_we    (out_we),
      .out_waddr (out_waddr),
      .out_wdata (out_wdata),
      .out_whilo (out_whilo),
      .out_hi    (out_hi),
      .out_lo    (out_lo),
      .occupancy (occupancy)
   );

   int n_checks = 0;
   int n_pass   = 0;
   bit mon_en   = 1'b0;

   typedef struct {
      logic [NCH-1:0]    we;
      logic [NCH*AW-1:0] waddr;
      logic [NCH*DW-1:0] wdata;
      logic              whilo;
      logic [DW-1:0]     hi;
      logic [DW-1:0]     lo;
   } ent_t;

   ent_t sb[$];
   ent_t mon_e;
   int   mon_sz;
   bit   mon_push, mon_pop;

   typedef struct {
      bit         iv;
      logic [7:0] d;
      bit         ord;
      bit         fl;
      logic [1:0] occ;
      bit         ov;
      bit         ir;
      logic [7:0] wd;
   } vec_t;

   vec_t tbl[16];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, want %0h", name, act, exp);
   endtask

   task automatic drive(input bit v, input logic [NCH-1:0] we, input logic [NCH*AW-1:0] wa,
                        input logic [NCH*DW-1:0] wd, input bit wh, input logic [DW-1:0] hi,
                        input logic [DW-1:0] lo);
      in_valid = v;
      in_we    = we;
      in_waddr = wa;
      in_wdata = wd;
      in_whilo = wh;
      in_hi    = hi;
      in_lo    = lo;
   endtask

   task automatic drive_d(input bit v, input logic [7:0] d);
      drive(v, 2'b11, {d[4:0], ~d[4:0]}, {32'hC0DE0000 | 32'(d), 32'(d)}, 1'b0, 32'h0, 32'h0);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference FIFO model: inputs are sampled mid-cycle, ahead of the edge that consumes them.
   always @(negedge clk) begin
      if (mon_en) begin
         mon_sz = sb.size();
         check("sb_out_valid", 64'(out_valid), 64'(mon_sz != 0));
         check("sb_in_ready",  64'(in_ready),  64'(mon_sz < 2));
         check("sb_occupancy", 64'(occupancy), 64'(mon_sz));
         if (mon_sz == 0) begin
            check("sb_idle_we",    64'(out_we),    64'd0);
            check("sb_idle_whilo", 64'(out_whilo), 64'd0);
         end
         if (rst || flush) begin
            sb.delete();
         end else begin
            mon_push = in_valid && (mon_sz < 2);
            mon_pop  = (mon_sz != 0) && out_ready;
            if (mon_pop) begin
               mon_e = sb.pop_front();
               check("sb_we",    64'(out_we),    64'(mon_e.we));
               check("sb_waddr", 64'(out_waddr), 64'(mon_e.waddr));
               check("sb_wdata", out_wdata,      mon_e.wdata);
               check("sb_whilo", 64'(out_whilo), 64'(mon_e.whilo));
               check("sb_hi",    64'(out_hi),    64'(mon_e.hi));
               check("sb_lo",    64'(out_lo),    64'(mon_e.lo));
            end
            if (mon_push)
               sb.push_back('{we: in_we, waddr: in_waddr, wdata: in_wdata,
                              whilo: in_whilo, hi: in_hi, lo: in_lo});
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Expected outputs describe the cycle in which the row's inputs are presented.
      //          iv  d      ord fl  occ  ov ir wd
      tbl[0]  = '{1, 8'h11, 0, 0, 2'd0, 0, 1, 8'h00};
      tbl[1]  = '{1, 8'h22, 0, 0, 2'd1, 1, 1, 8'h11};
      tbl[2]  = '{0, 8'h00, 0, 0, 2'd2, 1, 0, 8'h11};
      tbl[3]  = '{0, 8'h00, 1, 0, 2'd2, 1, 0, 8'h11};
      tbl[4]  = '{0, 8'h00, 1, 0, 2'd1, 1, 1, 8'h22};
      tbl[5]  = '{0, 8'h00, 0, 0, 2'd0, 0, 1, 8'h00};
      tbl[6]  = '{1, 8'hAA, 0, 0, 2'd0, 0, 1, 8'h00};
      tbl[7]  = '{1, 8'hBB, 1, 0, 2'd1, 1, 1, 8'hAA};
      tbl[8]  = '{0, 8'h00, 0, 0, 2'd1, 1, 1, 8'hBB};
      tbl[9]  = '{1, 8'h44, 0, 0, 2'd1, 1, 1, 8'hBB};
      tbl[10] = '{1, 8'h33, 0, 1, 2'd2, 1, 0, 8'hBB};
      tbl[11] = '{0, 8'h00, 1, 0, 2'd0, 0, 1, 8'h00};
      tbl[12] = '{0, 8'h00, 1, 0, 2'd0, 0, 1, 8'h00};
      tbl[13] = '{1, 8'h55, 0, 0, 2'd0, 0, 1, 8'h00};
      tbl[14] = '{1, 8'h66, 0, 1, 2'd1, 1, 1, 8'h55};
      tbl[15] = '{0, 8'h00, 1, 0, 2'd0, 0, 1, 8'h00};

      // Reset held for two edges while a push is offered.
      rst       = 1'b1;
      flush     = 1'b0;
      out_ready = 1'b0;
      drive_d(1'b1, 8'h77);
      step();
      mon_en = 1'b1;
      step();
      rst      = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_we",    64'(out_we),    64'd0);
      check("rst_occupancy", 64'(occupancy), 64'd0);
      check("rst_in_ready",  64'(in_ready),  64'd1);

      // Back-to-back streaming, one-cycle latency.
      out_ready = 1'b1;
      for (int i = 1; i <= 9; i++) begin
         step();
         if (i <= 8) drive_d(1'b1, 8'(i));
         else        in_valid = 1'b0;
         @(negedge clk);
         if (i > 1) begin
            check("stream_valid", 64'(out_valid), 64'd1);
            check("stream_data",  64'(out_wdata[31:0]), 64'(i - 1));
         end
         check("stream_occ_le1", 64'(occupancy <= 2'd1), 64'd1);
      end

      // Backpressure, simultaneous push/pop, flush in TWO and in ONE.
      for (int i = 0; i < 16; i++) begin
         step();
         drive_d(tbl[i].iv, tbl[i].d);
         out_ready = tbl[i].ord;
         flush     = tbl[i].fl;
         @(negedge clk);
         check($sformatf("vec%0d_occ", i), 64'(occupancy), 64'(tbl[i].occ));
         check($sformatf("vec%0d_ov", i),  64'(out_valid), 64'(tbl[i].ov));
         check($sformatf("vec%0d_ir", i),  64'(in_ready),  64'(tbl[i].ir));
         check($sformatf("vec%0d_we", i),  64'(out_we),    tbl[i].ov ? 64'd3 : 64'd0);
         if (tbl[i].ov)
            check($sformatf("vec%0d_wd", i), 64'(out_wdata[31:0]), 64'(tbl[i].wd));
      end

      // HI/LO-only entry, then drained.
      step();
      flush     = 1'b0;
      out_ready = 1'b1;
      drive(1'b1, 2'b00, 10'h3FF, {2{32'hFFFF_FFFF}}, 1'b1, 32'hDEADBEEF, 32'h12345678);
      step();
      in_valid = 1'b0;
      @(negedge clk);
      check("hl_valid", 64'(out_valid), 64'd1);
      check("hl_whilo", 64'(out_whilo), 64'd1);
      check("hl_hi",    64'(out_hi),    64'hDEADBEEF);
      check("hl_lo",    64'(out_lo),    64'h12345678);
      check("hl_we",    64'(out_we),    64'd0);
      step();
      @(negedge clk);
      check("hl_drain_valid", 64'(out_valid), 64'd0);
      check("hl_drain_whilo", 64'(out_whilo), 64'd0);
      check("hl_hi_retained", 64'(out_hi),    64'hDEADBEEF);

      // Reset while full.
      out_ready = 1'b0;
      step();
      drive_d(1'b1, 8'hA1);
      step();
      drive_d(1'b1, 8'hA2);
      step();
      in_valid = 1'b0;
      rst      = 1'b1;
      @(negedge clk);
      check("midrst_full", 64'(occupancy), 64'd2);
      step();
      rst       = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check("midrst_occ", 64'(occupancy), 64'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         @(negedge clk);
         check("midrst_no_emit", 64'(out_valid), 64'd0);
      end

      // Randomised traffic with bubbles, stalls and occasional flush.
      for (int i = 0; i < 400; i++) begin
         step();
         drive(($urandom_range(0, 2) != 0), 2'($urandom_range(0, 3)), 10'($urandom),
               {$urandom, $urandom}, 1'($urandom_range(0, 1)), $urandom, $urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 15) == 0);
      end
      step();
      in_valid  = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b1;
      repeat (4) step();
      @(negedge clk);
      check("final_empty", 64'(occupancy), 64'd0);
      mon_en = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
